// File: rtl/if_fetch_stage.sv
// if_fetch_stage
// Instruction-fetch stage downstream of the PC register. Issues PCF to a
// variable-latency instruction memory over req/ack, parks a fetched word in
// a one-entry hold buffer while decode is stalled, and loads IF/ID.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   PCF                 current PC from the PC register
//   imem_req/addr       fetch request and address (held until ack)
//   imem_ack/rdata      memory response and instruction word
//   Stall_D, Flush_D    decode stall / redirect from decode
//   Stall_IF            hold the PC register
//   InstrD, PCPlus4D,
//   ValidD              IF/ID pipeline register
//   FetchStallCnt,
//   FlushCnt            performance counters (only with IF_PERF_CNT_EN)
//
// Build option: define IF_PERF_CNT_EN to add the saturating counters.
//
// state  | meaning
// S_REQ  | request PCF; retire ack into IF/ID or into the hold buffer
// S_HOLD | fetched word parked while decode is stalled; no request
// S_DROP | squashed request still outstanding; wait for ack and discard

module if_fetch_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PCF,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        Stall_D,
  input  logic        Flush_D,
  output logic        Stall_IF,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
`ifdef IF_PERF_CNT_EN
  output logic [31:0] FetchStallCnt,
  output logic [15:0] FlushCnt,
`endif
  output logic        ValidD
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc4_q, hold_pc4_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  logic        req_c;
  logic        stall_if_c;
  logic [31:0] pcf_plus4;

  assign pcf_plus4 = PCF + 32'd4;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    hold_instr_d = hold_instr_q;
    hold_pc4_d   = hold_pc4_q;
    instr_d      = instr_q;
    pc4_d        = pc4_q;
    valid_d      = valid_q;
    req_c        = 1'b0;
    imem_addr    = addr_q;
    stall_if_c   = 1'b1;

    case (state_q)
      S_REQ: begin
        req_c     = 1'b1;
        imem_addr = PCF;
        addr_d    = PCF;
        if (Flush_D) begin
          // An un-acked request cannot be withdrawn; drain it in S_DROP.
          stall_if_c = 1'b0;
          state_d    = imem_ack ? S_REQ : S_DROP;
        end else if (imem_ack && !Stall_D) begin
          instr_d    = imem_rdata;
          pc4_d      = pcf_plus4;
          valid_d    = 1'b1;
          stall_if_c = 1'b0;
        end else if (imem_ack) begin
          hold_instr_d = imem_rdata;
          hold_pc4_d   = pcf_plus4;
          state_d      = S_HOLD;
        end else if (!Stall_D) begin
          valid_d = 1'b0;
        end
      end
      S_HOLD: begin
        stall_if_c = Stall_D;
        if (Flush_D) begin
          stall_if_c = 1'b0;
          state_d    = S_REQ;
        end else if (!Stall_D) begin
          instr_d = hold_instr_q;
          pc4_d   = hold_pc4_q;
          valid_d = 1'b1;
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        req_c = 1'b1;
        if (Flush_D) stall_if_c = 1'b0;
        if (imem_ack) state_d = S_REQ;
        if (!Flush_D && !Stall_D) valid_d = 1'b0;
      end
      default: state_d = S_REQ;
    endcase

    // Flush overrides every IF/ID update above.
    if (Flush_D) begin
      instr_d = NOP_INSTR;
      pc4_d   = 32'd0;
      valid_d = 1'b0;
    end
  end

  assign imem_req = req_c & rst;
  assign Stall_IF = stall_if_c | ~rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_REQ;
      addr_q       <= 32'd0;
      hold_instr_q <= 32'd0;
      hold_pc4_q   <= 32'd0;
      instr_q      <= NOP_INSTR;
      pc4_q        <= 32'd0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      hold_instr_q <= hold_instr_d;
      hold_pc4_q   <= hold_pc4_d;
      instr_q      <= instr_d;
      pc4_q        <= pc4_d;
      valid_q      <= valid_d;
    end
  end

  assign InstrD   = instr_q;
  assign PCPlus4D = pc4_q;
  assign ValidD   = valid_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_if_c && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
    if (Flush_D && flush_cnt_q != 16'hFFFF)         flush_cnt_d = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign FetchStallCnt = stall_cnt_q;
  assign FlushCnt      = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

  logic        clk;
  logic        rst;
  logic [31:0] PCF;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        Stall_D;
  logic        Flush_D;
  logic        Stall_IF;
  logic [31:0] InstrD;
  logic [31:0] PCPlus4D;
  logic        ValidD;
`ifdef IF_PERF_CNT_EN
  logic [31:0] FetchStallCnt;
  logic [15:0] FlushCnt;
`endif

  int checks = 0;
  int errors = 0;

  if_fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .PCF        (PCF),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .Stall_D    (Stall_D),
    .Flush_D    (Flush_D),
    .Stall_IF   (Stall_IF),
    .InstrD     (InstrD),
    .PCPlus4D   (PCPlus4D),
`ifdef IF_PERF_CNT_EN
    .FetchStallCnt (FetchStallCnt),
    .FlushCnt      (FlushCnt),
`endif
    .ValidD     (ValidD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; PCF = 32'd0; imem_ack = 1'b0; imem_rdata = 32'd0;
    Stall_D = 1'b0; Flush_D = 1'b0;
    #2;
    chk1 ("reset imem_req", imem_req, 1'b0);
    chk1 ("reset Stall_IF", Stall_IF, 1'b1);
    chk32("reset InstrD", InstrD, 32'h0);
    chk32("reset PCPlus4D", PCPlus4D, 32'h0);
    chk1 ("reset ValidD", ValidD, 1'b0);
    step();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_zero_wait();
    for (int i = 0; i < 3; i++) begin
      PCF = 32'(i * 4);
      imem_ack = 1'b1;
      imem_rdata = 32'h1000_0000 + 32'(i);
      #1;
      chk1 ("zw Stall_IF", Stall_IF, 1'b0);
      chk1 ("zw imem_req", imem_req, 1'b1);
      chk32("zw imem_addr", imem_addr, 32'(i * 4));
      step();
      chk32("zw InstrD", InstrD, 32'h1000_0000 + 32'(i));
      chk32("zw PCPlus4D", PCPlus4D, 32'(i * 4 + 4));
      chk1 ("zw ValidD", ValidD, 1'b1);
    end
  endtask

  task automatic test_latency();
    PCF = 32'h40; imem_ack = 1'b0; imem_rdata = 32'hBAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk1 ("lat imem_req", imem_req, 1'b1);
      chk32("lat imem_addr", imem_addr, 32'h40);
      chk1 ("lat Stall_IF", Stall_IF, 1'b1);
      step();
      chk1 ("lat bubble ValidD", ValidD, 1'b0);
    end
    imem_ack = 1'b1; imem_rdata = 32'h2222_2222;
    #1;
    chk32("lat ack addr", imem_addr, 32'h40);
    chk1 ("lat ack Stall_IF", Stall_IF, 1'b0);
    step();
    chk32("lat InstrD", InstrD, 32'h2222_2222);
    chk32("lat PCPlus4D", PCPlus4D, 32'h44);
    chk1 ("lat ValidD", ValidD, 1'b1);
  endtask

  task automatic test_stall_hold();
    PCF = 32'h50; imem_ack = 1'b1; imem_rdata = 32'h8C01_0004; Stall_D = 1'b1;
    #1;
    chk1("hold ack Stall_IF", Stall_IF, 1'b1);
    step();
    imem_ack = 1'b0; imem_rdata = 32'hBAD0_BAD0;
    #1;
    chk1 ("hold imem_req", imem_req, 1'b0);
    chk1 ("hold Stall_IF", Stall_IF, 1'b1);
    chk32("hold InstrD unchanged", InstrD, 32'h2222_2222);
    step();
    Stall_D = 1'b0;
    #1;
    chk1("hold release Stall_IF", Stall_IF, 1'b0);
    chk1("hold release imem_req", imem_req, 1'b0);
    step();
    chk32("hold InstrD", InstrD, 32'h8C01_0004);
    chk32("hold PCPlus4D", PCPlus4D, 32'h54);
    chk1 ("hold ValidD", ValidD, 1'b1);
  endtask

  task automatic test_flush_outstanding();
    PCF = 32'h80; imem_ack = 1'b0; Flush_D = 1'b1;
    #1;
    chk1 ("flush Stall_IF", Stall_IF, 1'b0);
    chk32("flush imem_addr", imem_addr, 32'h80);
    step();
    Flush_D = 1'b0; PCF = 32'h200;
    #1;
    chk1 ("flush ValidD", ValidD, 1'b0);
    chk32("flush InstrD nop", InstrD, 32'h0);
    chk32("drop imem_addr", imem_addr, 32'h80);
    chk1 ("drop imem_req", imem_req, 1'b1);
    chk1 ("drop Stall_IF", Stall_IF, 1'b1);
    step();
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    #1;
    chk32("drop ack addr", imem_addr, 32'h80);
    chk1 ("drop ack Stall_IF", Stall_IF, 1'b1);
    step();
    imem_ack = 1'b0;
    #1;
    chk1 ("drop discard ValidD", ValidD, 1'b0);
    chk32("drop discard InstrD", InstrD, 32'h0);
    chk32("after drop addr", imem_addr, 32'h200);
    chk1 ("after drop req", imem_req, 1'b1);
    imem_ack = 1'b1; imem_rdata = 32'h3333_3333;
    step();
    chk32("after drop InstrD", InstrD, 32'h3333_3333);
    chk32("after drop PCPlus4D", PCPlus4D, 32'h204);
  endtask

  task automatic test_flush_stall_ack();
    PCF = 32'h300; imem_ack = 1'b1; imem_rdata = 32'h4444_4444;
    Flush_D = 1'b1; Stall_D = 1'b1;
    #1;
    chk1("fsa Stall_IF", Stall_IF, 1'b0);
    step();
    Flush_D = 1'b0; Stall_D = 1'b0; imem_ack = 1'b0; PCF = 32'h400;
    #1;
    chk32("fsa InstrD", InstrD, 32'h0);
    chk1 ("fsa ValidD", ValidD, 1'b0);
    chk32("fsa PCPlus4D", PCPlus4D, 32'h0);
    chk1 ("fsa next req", imem_req, 1'b1);
    chk32("fsa next addr", imem_addr, 32'h400);
  endtask

  task automatic test_wrap();
    PCF = 32'hFFFF_FFFC; imem_ack = 1'b1; imem_rdata = 32'h5555_5555;
    step();
    chk32("wrap PCPlus4D", PCPlus4D, 32'h0);
    chk32("wrap InstrD", InstrD, 32'h5555_5555);
    chk1 ("wrap ValidD", ValidD, 1'b1);
  endtask

  task automatic test_reset_mid();
    PCF = 32'h500; imem_ack = 1'b0;
    step();
    #1;
    rst = 1'b0;
    #1;
    chk1("rst mid imem_req", imem_req, 1'b0);
    chk1("rst mid ValidD", ValidD, 1'b0);
    chk1("rst mid Stall_IF", Stall_IF, 1'b1);
    step();
    rst = 1'b1; PCF = 32'h600;
    #1;
    chk1 ("rst release req", imem_req, 1'b1);
    chk32("rst release addr", imem_addr, 32'h600);
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_latency();
    test_stall_hold();
    test_flush_outstanding();
    test_flush_stall_ack();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

- Instruction-fetch stage sitting directly downstream of the PC register.
- Issues the current PC to a variable-latency instruction memory over a req/ack handshake, and holds the fetched word in a one-entry buffer while decode is stalled.
- Loads the IF/ID pipeline register.
- Drives Stall_IF back to the PC register so the PC advances only when a fetch has retired into IF/ID or a redirect must be accepted.

## Interface
- NOP_INSTR, 32'h0000_0000, word loaded into InstrD on reset and flush (sll $0,$0,0)
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-low reset
- PCF  in  32  current PC from PC register
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  fetch address; stable while imem_req=1 and no ack
- imem_ack  in  1  memory response valid this cycle (may assert in first req cycle)
- imem_rdata  in  32  instruction word, valid when imem_ack=1
- Stall_D  in  1  decode stall from hazard unit
- Flush_D  in  1  branch/jump taken in decode; squash IF/ID and in-flight fetch
- Stall_IF  out  1  hold PC register
- InstrD  out  32  IF/ID instruction
- PCPlus4D  out  32  IF/ID PC+4
- ValidD  out  1  IF/ID holds a real instruction

## Operation
- States: S_REQ, S_HOLD, S_DROP. Registers: state, addr_q, hold_instr, hold_pc4.
- S_REQ:
  - imem_req=1, imem_addr=PCF, addr_q<=PCF each cycle.
  - ack & !Stall_D: IF/ID <= {rdata, PCF+4, 1}; Stall_IF=0; stay in S_REQ.
  - ack & Stall_D: hold <= {rdata, PCF+4}; Stall_IF=1; go to S_HOLD; IF/ID unchanged.
  - No ack: Stall_IF=1; IF/ID unchanged if Stall_D, else ValidD<=0 (bubble).
- S_HOLD:
  - imem_req=0, Stall_IF=Stall_D.
  - When !Stall_D: IF/ID <= {hold, 1}; go to S_REQ.
- S_DROP:
  - imem_req=1, imem_addr=addr_q, Stall_IF=1.
  - On ack: discard rdata and go to S_REQ.
  - IF/ID gets a bubble unless Stall_D.
- Flush_D has priority over Stall_D and over ack:
  - IF/ID <= {NOP_INSTR, 0, 0}; Stall_IF=0 so the PC loads the redirect target.
  - S_REQ without ack -> S_DROP (outstanding request must complete).
  - S_REQ with ack -> S_REQ (data discarded).
  - S_HOLD -> S_REQ (hold discarded).
  - S_DROP -> S_DROP, or S_REQ if ack.
- PC+4 arithmetic is 32-bit modulo: 32'hFFFF_FFFC -> 32'h0000_0000.

## Timing
- Reset (rst=0), asynchronous:
  - state=S_REQ; InstrD=NOP_INSTR, PCPlus4D=0, ValidD=0, addr_q=0, hold=0.
  - imem_req forced 0 and Stall_IF forced 1 while rst=0.
- Reset mid-request abandons the transaction; memory must also reset.
- Latency: ack in cycle N -> InstrD valid after posedge N.
- Zero-wait memory (ack every cycle): throughput 1 instruction/cycle.
- Handshake: imem_req stays high with a constant address until ack. No new request is issued in the ack cycle's successor unless the state is S_REQ.
- Stall_IF, imem_req and imem_addr are combinational from state, PCF, imem_ack, Stall_D and Flush_D. No combinational path from Stall_IF back into any input.

## Configuration
- IF_PERF_CNT_EN defined: adds outputs FetchStallCnt[31:0] (cycles with Stall_IF=1 and rst=1) and FlushCnt[15:0] (cycles with Flush_D=1). Both are reset to 0 and saturate at all-ones.
- IF_PERF_CNT_EN undefined: the ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Zero-wait memory, PCF=0,4,8, no stalls -> InstrD follows rdata each cycle; PCPlus4D=4,8,12; ValidD=1; Stall_IF=0.
- 3-cycle memory latency at PCF=0x40 -> imem_req/imem_addr=0x40 held for 3 cycles with Stall_IF=1; InstrD loaded after the ack edge; PCPlus4D=0x44.
- Ack with Stall_D=1 for 2 cycles (rdata=0x8C010004) -> S_HOLD with imem_req=0; InstrD=0x8C010004 loaded on the edge after Stall_D falls.
- Flush_D while request to 0x80 is outstanding:
  - Stall_IF=0 that cycle and ValidD=0 next.
  - imem_addr stays 0x80 until ack; the acked data is not loaded.
  - The next request uses the new PCF.
- Flush_D and Stall_D together with ack -> InstrD=NOP_INSTR, ValidD=0, state S_REQ.
- rst low during a wait -> imem_req=0 and ValidD=0 immediately; after release the first request is at PCF.
